// File: rtl/bist_sched_pkg.sv
// Shared types and sizing helpers for the BIST scheduler.
// Optional retry (see bist_scheduler) is enabled with BIST_SCHED_RETRY_EN.
package bist_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        NEXT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam int MAX_ENG = 8;

    // An index needs at least one bit even when only one engine exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ENG_IDX_W = idx_width(4);

endpackage

// File: rtl/bist_next_sel.sv
// Priority finder: lowest set mask bit above cur_idx, or the lowest set bit
// overall when first is high.
module bist_next_sel
    import bist_sched_pkg::*;
#(
    parameter int NUM_ENG = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_ENG-1:0] mask,
    input  logic [IDX_W-1:0]   cur_idx,
    input  logic               first,
    output logic [IDX_W-1:0]   next_idx,
    output logic               found
);

    // Scan downward so the last hit is the lowest qualifying bit.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur_idx)))) begin
                next_idx = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bist_scheduler.sv
// Sequences the enabled BIST engines in ascending order with a per-engine
// watchdog. Define BIST_SCHED_RETRY_EN to relaunch a failing engine once.
module bist_scheduler
    import bist_sched_pkg::*;
#(
    parameter int NUM_ENG   = 4,
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic               ABORT,
    input  logic [NUM_ENG-1:0] ENG_MASK,
    output logic [NUM_ENG-1:0] ENG_START,
    input  logic [NUM_ENG-1:0] ENG_END,
    input  logic [NUM_ENG-1:0] ENG_PASS,
    output logic               BUSY,
    output logic               DONE,
    output logic [NUM_ENG-1:0] FAIL_VEC,
    output logic [NUM_ENG-1:0] TIMEOUT_VEC
);

    localparam int IDX_W = idx_width(NUM_ENG);

    state_t               state;
    logic [NUM_ENG-1:0]   mask_q;
    logic [IDX_W-1:0]     idx;
    logic [TIMEOUT_W-1:0] timer;

    logic                 sel_first;
    logic [NUM_ENG-1:0]   sel_mask;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_found;
    logic [NUM_ENG-1:0]   sel_onehot;
    logic                 cur_end;
    logic                 cur_pass;
    logic                 timer_last;

    // In IDLE the search runs on the live mask so the first index is ready
    // on the same edge that accepts START.
    assign sel_first  = (state == IDLE);
    assign sel_mask   = sel_first ? ENG_MASK : mask_q;
    assign sel_onehot = NUM_ENG'(1) << sel_idx;
    assign cur_end    = ENG_END[idx];
    assign cur_pass   = ENG_PASS[idx];
    assign timer_last = (timer == TIMEOUT_W'(1));

    bist_next_sel #(
        .NUM_ENG (NUM_ENG),
        .IDX_W   (IDX_W)
    ) u_next_sel (
        .mask     (sel_mask),
        .cur_idx  (idx),
        .first    (sel_first),
        .next_idx (sel_idx),
        .found    (sel_found)
    );

`ifdef BIST_SCHED_RETRY_EN
    logic               retried;
    logic               attempt_done;
    logic               attempt_failed;
    logic [NUM_ENG-1:0] idx_onehot;

    assign attempt_done   = cur_end || timer_last;
    assign attempt_failed = cur_end ? ~cur_pass : 1'b1;
    assign idx_onehot     = NUM_ENG'(1) << idx;
`endif

    // ENG_START is asserted on the edge entering LAUNCH, so the pulse
    // occupies exactly the LAUNCH cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            mask_q      <= '0;
            idx         <= '0;
            timer       <= '0;
            ENG_START   <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            FAIL_VEC    <= '0;
            TIMEOUT_VEC <= '0;
`ifdef BIST_SCHED_RETRY_EN
            retried     <= 1'b0;
`endif
        end else begin
            ENG_START <= '0;
            if (ABORT) begin
                state <= IDLE;
                BUSY  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (START) begin
                            mask_q      <= ENG_MASK;
                            DONE        <= 1'b0;
                            FAIL_VEC    <= '0;
                            TIMEOUT_VEC <= '0;
                            BUSY        <= 1'b1;
`ifdef BIST_SCHED_RETRY_EN
                            retried     <= 1'b0;
`endif
                            if (sel_found) begin
                                idx       <= sel_idx;
                                ENG_START <= sel_onehot;
                                state     <= LAUNCH;
                            end else begin
                                state <= FINISH;
                            end
                        end
                    end
                    LAUNCH: begin
                        timer <= TIMEOUT_W'(TIMEOUT);
                        state <= WAIT;
                    end
                    WAIT: begin
`ifdef BIST_SCHED_RETRY_EN
                        if (attempt_done) begin
                            if (attempt_failed && !retried) begin
                                retried   <= 1'b1;
                                ENG_START <= idx_onehot;
                                state     <= LAUNCH;
                            end else begin
                                FAIL_VEC[idx]    <= attempt_failed;
                                TIMEOUT_VEC[idx] <= ~cur_end;
                                retried          <= 1'b0;
                                state            <= NEXT;
                            end
                        end else begin
                            timer <= timer - TIMEOUT_W'(1);
                        end
`else
                        if (cur_end) begin
                            FAIL_VEC[idx] <= ~cur_pass;
                            state         <= NEXT;
                        end else if (timer_last) begin
                            TIMEOUT_VEC[idx] <= 1'b1;
                            FAIL_VEC[idx]    <= 1'b1;
                            state            <= NEXT;
                        end else begin
                            timer <= timer - TIMEOUT_W'(1);
                        end
`endif
                    end
                    NEXT: begin
                        if (sel_found) begin
                            idx       <= sel_idx;
                            ENG_START <= sel_onehot;
                            state     <= LAUNCH;
                        end else begin
                            state <= FINISH;
                        end
                    end
                    FINISH: begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
